dmem_port_arbiter: RTL and testbench

Two-requester arbiter that shares the single data-cache port between the pipeline core (`read_data`/`cache_data_valid` side of the core) and the boot program loader. It sits between those two masters and the data cache. It grants one request at a time with round-robin fairness and holds the cache request until completion. A timeout counter guarantees forward progress if the cache never answers.

---
 rtl/dmem_port_arbiter_if.sv | 47 ++++
 rtl/dmem_port_arbiter.sv | 110 +++++++++++
 tb/tb_dmem_port_arbiter.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_port_arbiter_if.sv
// Bundle between the data-cache port arbiter, its two requesters and the cache.
// The arbiter takes the slave view; the surrounding system takes the master view.
interface dmem_port_arbiter_if;
    logic        core_req;
    logic        core_we;
    logic [31:0] core_addr;
    logic [31:0] core_din;
    logic [31:0] core_rdata;
    logic        core_valid;

    logic        ld_req;
    logic        ld_we;
    logic [31:0] ld_addr;
    logic [31:0] ld_din;
    logic [31:0] ld_rdata;
    logic        ld_valid;

    logic        cache_req;
    logic        cache_we;
    logic [31:0] cache_addr;
    logic [31:0] cache_din;
    logic [31:0] cache_rdata;
    logic        cache_data_valid;

    logic        grant;
    logic        err_timeout;

    modport slave (
        input  core_req, core_we, core_addr, core_din,
        output core_rdata, core_valid,
        input  ld_req, ld_we, ld_addr, ld_din,
        output ld_rdata, ld_valid,
        output cache_req, cache_we, cache_addr, cache_din,
        input  cache_rdata, cache_data_valid,
        output grant, err_timeout
    );

    modport master (
        output core_req, core_we, core_addr, core_din,
        input  core_rdata, core_valid,
        output ld_req, ld_we, ld_addr, ld_din,
        input  ld_rdata, ld_valid,
        input  cache_req, cache_we, cache_addr, cache_din,
        output cache_rdata, cache_data_valid,
        input  grant, err_timeout
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin sharing of the data-cache port between the core and the
// boot loader, with a timeout that forces completion if the cache stalls.
module dmem_port_arbiter #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst,
    dmem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [15:0] TLAST = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] din_q, din_d;
    logic        grant_q, grant_d;
    logic        last_q, last_d;
    logic        err_q, err_d;
    logic [15:0] tcnt_q, tcnt_d;

    logic        any_req;
    logic        win;
    logic        hit;
    logic        expire;
    logic        fin;

    // On a tie the requester that did not own the port last time wins.
    always_comb begin
        any_req = bus.core_req | bus.ld_req;
        win     = bus.ld_req & (~bus.core_req | ~last_q);
        hit     = (state_q == BUSY) & bus.cache_data_valid;
        expire  = (state_q == BUSY) & ~bus.cache_data_valid
                & (tcnt_q == TLAST);
        fin     = hit | expire;
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        din_d   = din_q;
        grant_d = grant_q;
        last_d  = last_q;
        err_d   = err_q;
        tcnt_d  = tcnt_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = BUSY;
                    we_d    = win ? bus.ld_we   : bus.core_we;
                    addr_d  = win ? bus.ld_addr : bus.core_addr;
                    din_d   = win ? bus.ld_din  : bus.core_din;
                    grant_d = win;
                    last_d  = win;
                    tcnt_d  = '0;
                end
            end
            BUSY: begin
                if (fin) begin
                    state_d = DONE;
                    err_d   = err_q | expire;
                end else begin
                    tcnt_d = tcnt_q + 16'd1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            err_q   <= 1'b0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            err_q   <= err_d;
            tcnt_q  <= tcnt_d;
        end
    end

    // Completion is combinational so the winner sees it in the same cycle.
    assign bus.cache_req   = (state_q == BUSY);
    assign bus.cache_we    = we_q;
    assign bus.cache_addr  = addr_q;
    assign bus.cache_din   = din_q;
    assign bus.core_valid  = fin & ~grant_q;
    assign bus.ld_valid    = fin & grant_q;
    assign bus.core_rdata  = (hit & ~grant_q) ? bus.cache_rdata : '0;
    assign bus.ld_rdata    = (hit & grant_q) ? bus.cache_rdata : '0;
    assign bus.grant       = grant_q;
    assign bus.err_timeout = err_q;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomised and directed bench for dmem_port_arbiter against a
// transaction-level model of port ownership.
module tb_dmem_port_arbiter;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    dmem_port_arbiter_if bus();

    dmem_port_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%h, want 0x%h", nm, act, exp);
        end
    endtask

    // Model: who owns the port, for how many cycles, and how long the
    // post-completion gap still lasts before a new grant may happen.
    bit          m_busy = 1'b0;
    bit          m_win = 1'b0;
    int          m_age = 0;
    int          m_gap = 0;
    bit          m_last = 1'b1;
    bit          m_grant = 1'b0;
    bit          m_err = 1'b0;
    bit          m_we = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_din = '0;
    bit          c_done = 1'b0;
    bit          c_to = 1'b0;

    int n_fin_core = 0;
    int n_fin_ld = 0;
    int cnt_cv = 0;
    int cnt_lv = 0;
    bit glog[$];

    function automatic bit pick(input bit c, input bit l, input bit last);
        if (c && l) return !last;
        return l;
    endfunction

    function automatic int gl(input int i);
        if (i < glog.size()) return int'(glog[i]);
        return 2;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy  <= 1'b0;
            m_win   <= 1'b0;
            m_age   <= 0;
            m_gap   <= 0;
            m_last  <= 1'b1;
            m_grant <= 1'b0;
            m_err   <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_din   <= '0;
        end else if (m_busy) begin
            if (c_done) begin
                m_busy <= 1'b0;
                m_gap  <= 1;
                if (c_to) m_err <= 1'b1;
            end else begin
                m_age <= m_age + 1;
            end
        end else if (m_gap > 0) begin
            m_gap <= m_gap - 1;
        end else if (bus.core_req || bus.ld_req) begin
            m_win   <= pick(bus.core_req, bus.ld_req, m_last);
            m_last  <= pick(bus.core_req, bus.ld_req, m_last);
            m_grant <= pick(bus.core_req, bus.ld_req, m_last);
            if (pick(bus.core_req, bus.ld_req, m_last)) begin
                m_we   <= bus.ld_we;
                m_addr <= bus.ld_addr;
                m_din  <= bus.ld_din;
            end else begin
                m_we   <= bus.core_we;
                m_addr <= bus.core_addr;
                m_din  <= bus.core_din;
            end
            m_busy <= 1'b1;
            m_age  <= 1;
        end
    end

    always @(negedge clk) begin : cmp
        logic [31:0] rd;
        if (rst) begin
            c_to   = m_busy && !bus.cache_data_valid && m_age == TO;
            c_done = m_busy && (bus.cache_data_valid || c_to);
            rd = (m_busy && bus.cache_data_valid) ? bus.cache_rdata : 32'h0;
            chk("cache_req", 32'(bus.cache_req), 32'(m_busy));
            if (m_busy) begin
                chk("cache_we", 32'(bus.cache_we), 32'(m_we));
                chk("cache_addr", bus.cache_addr, m_addr);
                chk("cache_din", bus.cache_din, m_din);
            end
            chk("core_valid", 32'(bus.core_valid), 32'(c_done && !m_win));
            chk("ld_valid", 32'(bus.ld_valid), 32'(c_done && m_win));
            chk("core_rdata", bus.core_rdata, (c_done && !m_win) ? rd : 0);
            chk("ld_rdata", bus.ld_rdata, (c_done && m_win) ? rd : 0);
            chk("grant", 32'(bus.grant), 32'(m_grant));
            chk("err_timeout", 32'(bus.err_timeout), 32'(m_err));
            if (c_done && !m_win) n_fin_core++;
            if (c_done && m_win) n_fin_ld++;
            if (bus.core_valid) begin
                cnt_cv++;
                glog.push_back(1'b0);
            end
            if (bus.ld_valid) begin
                cnt_lv++;
                glog.push_back(1'b1);
            end
        end else begin
            c_to   = 1'b0;
            c_done = 1'b0;
        end
    end

    bit          auto_on = 1'b0;
    int unsigned new_pct = 0;
    int unsigned renew_pct = 0;
    int unsigned cdv_pct = 0;
    int          seen_core = 0;
    int          seen_ld = 0;

    task automatic rnd_core();
        bus.core_req  = 1'b1;
        bus.core_we   = 1'($urandom_range(1));
        bus.core_addr = $urandom;
        bus.core_din  = $urandom;
    endtask

    task automatic rnd_ld();
        bus.ld_req  = 1'b1;
        bus.ld_we   = 1'($urandom_range(1));
        bus.ld_addr = $urandom;
        bus.ld_din  = $urandom;
    endtask

    task automatic tick();
        bit fc;
        bit fl;
        @(posedge clk);
        #1;
        fc = (n_fin_core != seen_core);
        fl = (n_fin_ld != seen_ld);
        seen_core = n_fin_core;
        seen_ld = n_fin_ld;
        if (auto_on) begin
            if (bus.core_req) begin
                if (fc) begin
                    if ($urandom_range(99) < renew_pct) rnd_core();
                    else bus.core_req = 1'b0;
                end
            end else if ($urandom_range(99) < new_pct) begin
                rnd_core();
            end
            if (bus.ld_req) begin
                if (fl) begin
                    if ($urandom_range(99) < renew_pct) rnd_ld();
                    else bus.ld_req = 1'b0;
                end
            end else if ($urandom_range(99) < new_pct) begin
                rnd_ld();
            end
            bus.cache_data_valid = ($urandom_range(99) < cdv_pct);
            bus.cache_rdata = $urandom;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drain(input string nm, input int budget);
        new_pct = 0;
        renew_pct = 0;
        for (int i = 0; i < budget; i++) begin
            if (!bus.core_req && !bus.ld_req && !m_busy && m_gap == 0)
                return;
            tick();
        end
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got no drain in %0d cycles, want idle", nm, budget);
    endtask

    task automatic wait_n(input string nm, input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (glog.size() >= n) return;
            tick();
        end
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got %0d completions, want %0d", nm, glog.size(), n);
    endtask

    task automatic clr_log();
        glog.delete();
        cnt_cv = 0;
        cnt_lv = 0;
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, "_cache_req"}, 32'(bus.cache_req), 0);
        chk({nm, "_cache_we"}, 32'(bus.cache_we), 0);
        chk({nm, "_cache_addr"}, bus.cache_addr, 0);
        chk({nm, "_cache_din"}, bus.cache_din, 0);
        chk({nm, "_core_valid"}, 32'(bus.core_valid), 0);
        chk({nm, "_ld_valid"}, 32'(bus.ld_valid), 0);
        chk({nm, "_grant"}, 32'(bus.grant), 0);
        chk({nm, "_err"}, 32'(bus.err_timeout), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got time limit, want $finish");
        $fatal(1);
    end

    initial begin
        bus.core_req = 1'b0;
        bus.core_we = 1'b0;
        bus.core_addr = '0;
        bus.core_din = '0;
        bus.ld_req = 1'b0;
        bus.ld_we = 1'b0;
        bus.ld_addr = '0;
        bus.ld_din = '0;
        bus.cache_rdata = '0;
        bus.cache_data_valid = 1'b0;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outs("rst");
        rst = 1'b1;
        tick();

        // Simultaneous writes straight out of reset: core first.
        clr_log();
        auto_on = 1'b1;
        new_pct = 0;
        renew_pct = 0;
        cdv_pct = 100;
        bus.core_req = 1'b1;
        bus.core_we = 1'b1;
        bus.core_addr = 32'h200;
        bus.core_din = 32'h1111_2222;
        bus.ld_req = 1'b1;
        bus.ld_we = 1'b1;
        bus.ld_addr = 32'h300;
        bus.ld_din = 32'h3333_4444;
        wait_n("sim_wait", 2, 60);
        drain("sim_drain", 60);
        chk("sim_first", 32'(gl(0)), 0);
        chk("sim_second", 32'(gl(1)), 1);
        chk("sim_core_cnt", 32'(cnt_cv), 1);
        chk("sim_ld_cnt", 32'(cnt_lv), 1);

        // Continuous contention alternates owners.
        clr_log();
        new_pct = 100;
        renew_pct = 100;
        cdv_pct = 100;
        wait_n("rr_wait", 6, 100);
        drain("rr_drain", 100);
        for (int i = 0; i < 6; i++)
            chk($sformatf("rr_grant%0d", i), 32'(gl(i)), 32'(i % 2));

        // Core-only read answered in the third busy cycle.
        auto_on = 1'b0;
        bus.cache_data_valid = 1'b0;
        clr_log();
        bus.core_req = 1'b1;
        bus.core_we = 1'b0;
        bus.core_addr = 32'h100;
        tick();
        @(negedge clk);
        chk("rd_req_b1", 32'(bus.cache_req), 1);
        chk("rd_addr_b1", bus.cache_addr, 32'h100);
        ticks(2);
        bus.cache_data_valid = 1'b1;
        bus.cache_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        chk("rd_valid", 32'(bus.core_valid), 1);
        chk("rd_rdata", bus.core_rdata, 32'hCAFE_F00D);
        tick();
        bus.cache_data_valid = 1'b0;
        bus.core_req = 1'b0;
        @(negedge clk);
        chk("rd_done_req", 32'(bus.cache_req), 0);
        tick();
        chk("rd_core_cnt", 32'(cnt_cv), 1);
        chk("rd_ld_cnt", 32'(cnt_lv), 0);

        // Answer in the last allowed cycle, then stray pulses.
        bus.core_req = 1'b1;
        bus.core_addr = 32'h44;
        ticks(8);
        bus.cache_data_valid = 1'b1;
        bus.cache_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("co_valid", 32'(bus.core_valid), 1);
        chk("co_rdata", bus.core_rdata, 32'h1234_5678);
        tick();
        bus.core_req = 1'b0;
        bus.cache_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("stray_done_v", 32'(bus.core_valid), 0);
        chk("stray_done_rd", bus.core_rdata, 0);
        tick();
        @(negedge clk);
        chk("stray_idle_req", 32'(bus.cache_req), 0);
        chk("co_err", 32'(bus.err_timeout), 0);
        tick();
        bus.cache_data_valid = 1'b0;
        @(negedge clk);
        chk("stray_idle_req2", 32'(bus.cache_req), 0);

        // Loader read the cache never answers.
        tick();
        bus.ld_req = 1'b1;
        bus.ld_we = 1'b0;
        bus.ld_addr = 32'h80;
        ticks(7);
        @(negedge clk);
        chk("to_early", 32'(bus.ld_valid), 0);
        tick();
        @(negedge clk);
        chk("to_valid", 32'(bus.ld_valid), 1);
        chk("to_rdata", bus.ld_rdata, 0);
        tick();
        bus.ld_req = 1'b0;
        @(negedge clk);
        chk("to_err", 32'(bus.err_timeout), 1);
        tick();
        bus.core_req = 1'b1;
        bus.core_we = 1'b0;
        bus.core_addr = 32'h90;
        ticks(2);
        bus.cache_data_valid = 1'b1;
        bus.cache_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        chk("to_next_v", 32'(bus.core_valid), 1);
        chk("to_next_rd", bus.core_rdata, 32'h0BAD_F00D);
        tick();
        bus.cache_data_valid = 1'b0;
        bus.core_req = 1'b0;
        @(negedge clk);
        chk("to_sticky", 32'(bus.err_timeout), 1);

        // Random traffic with stray and late cache answers.
        tick();
        auto_on = 1'b1;
        new_pct = 60;
        renew_pct = 50;
        cdv_pct = 30;
        ticks(400);
        drain("rnd_drain", 200);

        // Reset in the middle of a busy request.
        auto_on = 1'b0;
        bus.cache_data_valid = 1'b0;
        bus.core_req = 1'b1;
        bus.core_addr = 32'h500;
        ticks(2);
        #2;
        bus.cache_data_valid = 1'b1;
        rst = 1'b0;
        #1;
        chk_reset_outs("mid");
        bus.core_req = 1'b0;
        tick();
        bus.cache_data_valid = 1'b0;
        rst = 1'b1;
        clr_log();
        auto_on = 1'b1;
        new_pct = 0;
        renew_pct = 0;
        cdv_pct = 100;
        rnd_core();
        rnd_ld();
        wait_n("post_wait", 1, 40);
        chk("post_first", 32'(gl(0)), 0);
        drain("post_drain", 60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
